bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have parameter BIN_W, default 16, giving the binary input width (range 4..32).
REQ-002 The block SHALL have parameter DIGITS, default 5, giving the BCD output digit count (range 1..10).
REQ-003 The block SHALL have parameter ALL1_ERR, default 1; when 1, an all-ones input is an error code, not a number.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1, meaning Binary holds a value to convert.
REQ-007 The block SHALL have port Binary, input, BIN_W, the unsigned binary operand.
REQ-008 The block SHALL have port in_ready, output, 1, meaning the block accepts an operand this cycle.
REQ-009 The block SHALL have port out_valid, output, 1, meaning BCD, ovf and err are valid.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-011 The block SHALL have port BCD, output, 4*DIGITS, packed BCD with the least significant digit in bits [3:0].
REQ-012 The block SHALL have port ovf, output, 1, meaning the value exceeds 10^DIGITS-1.
REQ-013 The block SHALL have port err, output, 1, meaning the all-ones error code was received.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-015 IDLE->SHIFT SHALL occur on in_valid&&in_ready: capture Binary into the shift register, clear the BCD accumulator and ovf, load err, and set the bit counter to 0.
REQ-016 Each SHIFT cycle SHALL first add 3 to every accumulator digit greater than 4, then shift {accumulator, operand} left by 1, with the operand MSB entering accumulator bit 0.
REQ-017 SHIFT SHALL last exactly BIN_W cycles; out_valid SHALL assert BIN_W cycles after the accept edge (latency BIN_W, fixed for all operands).
REQ-018 ovf SHALL be set, sticky for the conversion, when the accumulator MSB is 1 at a shift (a bit would be lost).
REQ-019 err SHALL be 1 when ALL1_ERR=1 and the captured Binary is all ones; it SHALL be 0 when ALL1_ERR=0.
REQ-020 In DONE with ovf=1 or err=1, BCD SHALL read all ones (4*DIGITS bits of 1); otherwise BCD SHALL read the converted accumulator.
REQ-021 An err conversion SHALL still take BIN_W cycles; when err=1, ovf SHALL read 0.
REQ-022 DONE SHALL hold BCD, ovf, err and out_valid stable while out_ready=0.
REQ-023 DONE->IDLE SHALL occur on out_ready=1, so in_ready rises on the next cycle; an operand cannot be accepted in the same cycle as the result is taken.
REQ-024 in_valid during SHIFT or DONE SHALL be ignored, and Binary changes after acceptance SHALL not affect the result.
REQ-025 Max throughput SHALL be one conversion per BIN_W+2 cycles.

Reset
REQ-026 While rst=1 at a clock edge, the state SHALL become IDLE and the counter 0, and the outputs SHALL become in_ready=1, out_valid=0, BCD=0, ovf=0, err=0.
REQ-027 rst SHALL take priority over every handshake; rst during SHIFT or DONE SHALL discard the conversion with no out_valid pulse.
REQ-028 The first operand SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-029 The bench SHALL drive default params, Binary=0 with in_valid for 1 cycle, out_ready=1, and SHALL check out_valid exactly 16 cycles after accept with BCD=20'h00000, ovf=0, err=0.
REQ-030 The bench SHALL drive default params, Binary=16'd65534, and SHALL check BCD=20'h65534, ovf=0, err=0; it SHALL repeat with 16'd9999 -> 20'h09999.
REQ-031 The bench SHALL drive default params, Binary=16'hFFFF, and SHALL check BCD=20'hFFFFF, err=1, ovf=0 after 16 cycles; with ALL1_ERR=0 it SHALL check 20'h65535, err=0.
REQ-032 The bench SHALL drive BIN_W=12, DIGITS=3, Binary=12'd1000, and SHALL check BCD=12'hFFF, ovf=1; it SHALL check Binary=12'd999 -> 12'h999, ovf=0.
REQ-033 The bench SHALL drive Binary=16'd1234 with out_ready=0 for 10 cycles after out_valid, and SHALL check that outputs hold 20'h01234 and in_ready=0 throughout, that in_ready=1 one cycle after out_ready=1, and that in_valid pulses during SHIFT are ignored.
REQ-034 The bench SHALL start a conversion of 16'd4321 and assert rst for 1 cycle at SHIFT cycle 7, then check no out_valid pulse, all outputs at reset values, and that a new 16'd42 converts to 20'h00042.

Source files
------------

// File: rtl/bin2bcd_if.sv
// bin2bcd_if -- operand/result handshake bundle for bin2bcd_seq.
//
// Signals:
//   in_valid  : producer has an operand on Binary
//   Binary    : unsigned operand, BIN_W bits
//   in_ready  : converter accepts an operand this cycle
//   out_valid : BCD/ovf/err carry a finished result
//   out_ready : consumer takes the result this cycle
//   BCD       : packed BCD result, least significant digit in [3:0]
//   ovf       : value does not fit in DIGITS decimal digits
//   err       : all-ones error code was received
//
// Modports: master = producer/consumer side, slave = converter side.
interface bin2bcd_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) ();
  logic                  in_valid;
  logic [BIN_W-1:0]      Binary;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   BCD;
  logic                  ovf;
  logic                  err;

  modport master (
    output in_valid, Binary, out_ready,
    input  in_ready, out_valid, BCD, ovf, err
  );

  modport slave (
    input  in_valid, Binary, out_ready,
    output in_ready, out_valid, BCD, ovf, err
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential binary to packed-BCD converter (shift-and-add-3).
//
// One operand is converted at a time with a fixed latency of BIN_W cycles
// from the accept edge to out_valid, independent of the operand value.
//
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous active-high reset
//   bus : bin2bcd_if.slave handshake bundle (in_valid/Binary/in_ready,
//         out_valid/out_ready/BCD/ovf/err)
//
// Parameters:
//   BIN_W    : operand width (4..32)
//   DIGITS   : BCD digits produced (1..10)
//   ALL1_ERR : when nonzero, an all-ones operand is reported as err
module bin2bcd_seq #(
  parameter int BIN_W    = 16,
  parameter int DIGITS   = 5,
  parameter int ALL1_ERR = 1
) (
  input  logic      clk,
  input  logic      rst,
  bin2bcd_if.slave  bus
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   sr_q, sr_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   acc_adj;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  // Add 3 to every digit above 4 so the following doubling carries
  // correctly into the next decimal digit.
  function automatic logic [ACC_W-1:0] bcd_adjust(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] res;
    res = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] > 4'd4) begin
        res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

  // Overflow and error results are presented as an all-ones BCD word.
  function automatic logic [ACC_W-1:0] bcd_saturate(input logic [ACC_W-1:0] acc,
                                                    input logic              sat);
    return sat ? {ACC_W{1'b1}} : acc;
  endfunction

  assign acc_adj = bcd_adjust(acc_q);

  // State register; only control state is reset, the datapath is
  // always reloaded on accept before it is observed.
  always_ff @(posedge clk) begin
    sr_q  <= sr_d;
    acc_q <= acc_d;
    ovf_q <= ovf_d;
    err_q <= err_d;
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, one adjust-and-shift per SHIFT cycle
  always_comb begin
    sr_d  = sr_q;
    acc_d = acc_q;
    ovf_d = ovf_q;
    err_d = err_q;
    if (state_q == IDLE && bus.in_valid) begin
      sr_d  = bus.Binary;
      acc_d = '0;
      ovf_d = 1'b0;
      err_d = (ALL1_ERR != 0) && (&bus.Binary);
    end else if (state_q == SHIFT) begin
      // A one leaving the top of the adjusted accumulator is a lost digit.
      acc_d = {acc_adj[ACC_W-2:0], sr_q[BIN_W-1]};
      sr_d  = {sr_q[BIN_W-2:0], 1'b0};
      ovf_d = ovf_q | acc_adj[ACC_W-1];
    end
  end

  // Outputs: results are visible only in DONE, zero elsewhere
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = 1'b0;
    bus.BCD       = '0;
    bus.ovf       = 1'b0;
    bus.err       = 1'b0;
    if (state_q == DONE) begin
      bus.out_valid = 1'b1;
      bus.BCD       = bcd_saturate(acc_q, ovf_q | err_q);
      bus.ovf       = ovf_q & ~err_q;
      bus.err       = err_q;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq -- scoreboard bench for bin2bcd_seq.
// Three instances: default (16b/5 digits/err on), ALL1_ERR=0, and 12b/3 digits.
// Expected results come from a decimal reference model and are queued at
// issue time; a negedge monitor pops and compares on each new out_valid.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bin2bcd_if #(.BIN_W(16), .DIGITS(5)) if0 ();
  bin2bcd_if #(.BIN_W(16), .DIGITS(5)) if1 ();
  bin2bcd_if #(.BIN_W(12), .DIGITS(3)) if2 ();

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .ALL1_ERR(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .ALL1_ERR(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  bin2bcd_seq #(.BIN_W(12), .DIGITS(3), .ALL1_ERR(1)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  typedef struct {
    logic [39:0] bcd;
    logic        ovf;
    logic        err;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int   cyc  = 0;
  int   npass = 0;
  int   ntot  = 0;
  logic pv0 = 1'b0, pv1 = 1'b0, pv2 = 1'b0;
  logic rr_en = 1'b0, rr_bit = 1'b1, or0 = 1'b1;

  // dut0 consumer: either randomly stalling or under direct test control
  assign if0.out_ready = rr_en ? rr_bit : or0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) rr_bit <= 1'($urandom_range(0, 1));

  task automatic check(input string nm, input int d, input logic [39:0] act,
                       input logic [39:0] want);
    ntot++;
    if (act === want) npass++;
    else $display("FAIL %s dut%0d: got %h, want %h (cycle %0d)", nm, d, act, want, cyc);
  endtask

  // Reference: plain decimal arithmetic on the operand value
  function automatic exp_t model(input int d, input longint v);
    exp_t   e;
    int     bw, dg;
    longint lim, x;
    bw = (d == 2) ? 12 : 16;
    dg = (d == 2) ? 3 : 5;
    e.bcd = '0; e.ovf = 1'b0; e.err = 1'b0; e.acc = 0;
    lim = 1;
    for (int i = 0; i < dg; i++) lim = lim * 10;
    if (d != 1 && v == (longint'(1) << bw) - 1) begin
      e.err = 1'b1;
      e.bcd = (40'd1 << (4 * dg)) - 40'd1;
    end else if (v >= lim) begin
      e.ovf = 1'b1;
      e.bcd = (40'd1 << (4 * dg)) - 40'd1;
    end else begin
      x = v;
      for (int i = 0; i < dg; i++) begin
        e.bcd[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return e;
  endfunction

  // {in_ready, out_valid, ovf, err}
  function automatic logic [3:0] flags(input int d);
    case (d)
      0:       return {if0.in_ready, if0.out_valid, if0.ovf, if0.err};
      1:       return {if1.in_ready, if1.out_valid, if1.ovf, if1.err};
      default: return {if2.in_ready, if2.out_valid, if2.ovf, if2.err};
    endcase
  endfunction

  function automatic logic [39:0] bcdv(input int d);
    case (d)
      0:       return 40'(if0.BCD);
      1:       return 40'(if1.BCD);
      default: return 40'(if2.BCD);
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic mon(input int d, input logic pv);
    exp_t        x;
    logic [3:0]  f;
    f = flags(d);
    if (!f[2] || pv) return;
    if (qsize(d) == 0) begin
      check("unexpected_out_valid", d, {39'd0, f[2]}, 40'd0);
      return;
    end
    case (d)
      0:       x = q0.pop_front();
      1:       x = q1.pop_front();
      default: x = q2.pop_front();
    endcase
    check("bcd", d, bcdv(d), x.bcd);
    check("ovf", d, {39'd0, f[1]}, {39'd0, x.ovf});
    check("err", d, {39'd0, f[0]}, {39'd0, x.err});
    check("latency", d, 40'(cyc - x.acc), 40'((d == 2) ? 12 : 16));
  endtask

  always @(negedge clk) begin
    mon(0, pv0); pv0 = if0.out_valid;
    mon(1, pv1); pv1 = if1.out_valid;
    mon(2, pv2); pv2 = if2.out_valid;
  end

  // Present one operand; the accept edge is the next rising edge.
  task automatic issue(input int d, input logic [31:0] v);
    exp_t e;
    int   n;
    n = 0;
    while (!flags(d)[3]) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        check("in_ready_timeout", d, {39'd0, flags(d)[3]}, 40'd1);
        return;
      end
    end
    e = model(d, longint'(v));
    e.acc = cyc + 1;
    case (d)
      0:       begin if0.in_valid = 1'b1; if0.Binary = v[15:0]; q0.push_back(e); end
      1:       begin if1.in_valid = 1'b1; if1.Binary = v[15:0]; q1.push_back(e); end
      default: begin if2.in_valid = 1'b1; if2.Binary = v[11:0]; q2.push_back(e); end
    endcase
    @(posedge clk);
    #1;
    // Scramble the operand after acceptance; the result must not change.
    case (d)
      0:       begin if0.in_valid = 1'b0; if0.Binary = 16'($urandom); end
      1:       begin if1.in_valid = 1'b0; if1.Binary = 16'($urandom); end
      default: begin if2.in_valid = 1'b0; if2.Binary = 12'($urandom); end
    endcase
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", -1, 40'(q0.size() + q1.size() + q2.size()), 40'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    rst = 1'b1;
    if0.in_valid = 1'b0; if0.Binary = '0;
    if1.in_valid = 1'b0; if1.Binary = '0; if1.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.Binary = '0; if2.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset_flags", d, {36'd0, flags(d)}, {36'd0, 4'b1000});
      check("reset_bcd", d, bcdv(d), 40'd0);
    end

    // First operand on the first edge after reset release
    rst = 1'b0;
    issue(0, 32'd0);
    wait_idle();

    // Directed boundary values
    issue(0, 32'd65534);
    issue(0, 32'd9999);
    issue(0, 32'hFFFF);
    issue(1, 32'hFFFF);
    issue(1, 32'd10000);
    issue(2, 32'd1000);
    issue(2, 32'd999);
    issue(2, 32'hFFF);
    issue(2, 32'd0);
    wait_idle();

    // Randomized operands, dut0 consumer stalls randomly
    rr_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      issue(0, 32'($urandom_range(0, 65535)));
      issue(1, 32'($urandom_range(0, 65535)));
      issue(2, 32'($urandom_range(0, 4095)));
    end
    wait_idle();
    rr_en = 1'b0;
    or0   = 1'b1;
    @(negedge clk);

    // Backpressure hold and ignored in_valid during SHIFT
    or0 = 1'b0;
    issue(0, 32'd1234);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if0.in_valid = 1'b1;
      if0.Binary   = 16'($urandom);
      check("shift_in_ready", 0, {39'd0, if0.in_ready}, 40'd0);
    end
    @(negedge clk);
    if0.in_valid = 1'b0;
    n = 0;
    while (!if0.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("hold_wait", 0, {39'd0, if0.out_valid}, 40'd1);
    for (int k = 0; k < 10; k++) begin
      check("hold_bcd", 0, bcdv(0), 40'h01234);
      check("hold_flags", 0, {36'd0, flags(0)}, {36'd0, 4'b0100});
      @(negedge clk);
    end
    or0 = 1'b1;
    @(negedge clk);
    check("ready_after_take", 0, {36'd0, flags(0)}, {36'd0, 4'b1000});
    wait_idle();

    // Reset in the middle of a conversion
    issue(0, 32'd4321);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_flags", 0, {36'd0, flags(0)}, {36'd0, 4'b1000});
    check("midrst_bcd", 0, bcdv(0), 40'd0);
    rst = 1'b0;
    q0.delete();
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (if0.out_valid) seen++;
    end
    check("no_out_valid_after_rst", 0, 40'(seen), 40'd0);
    issue(0, 32'd42);
    wait_idle();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
